// File: rtl/rv32m_sequencer.sv
// rtl/rv32m_sequencer.sv - RV32M multiply/divide sequencer
//
// Sequences one M-extension operation at a time onto an external iterative
// multiplier and an external iterative divider. Division by zero and signed
// overflow are answered locally. A one-entry cache keeps the last divider
// quotient/remainder pair, so that a div followed by a rem (or the reverse)
// on the same operands does not run the divider a second time.
//
// Ports:
//   CLK, nRST                      clock; synchronous active-low reset
//   start, funct3, rs1_data,       M-op request from execute (start is held
//   rs2_data                       while stall=1)
//   flush                          kill the in-flight M-op
//   stall, done, result            pipeline hold, result-valid pulse, result
//   mul_start, mul_signed_a/b      multiplier command
//   mul_done, mul_product          multiplier response
//   div_start, div_signed          divider command
//   div_done, div_quotient,        divider response
//   div_remainder
//   op_a, op_b                     registered operands to both units
//   abort                          one-cycle kill to both units
module rv32m_sequencer #(
  parameter bit DIV_CACHE_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic        mul_start,
  output logic        mul_signed_a,
  output logic        mul_signed_b,
  input  logic        mul_done,
  input  logic [63:0] mul_product,
  output logic        div_start,
  output logic        div_signed,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        abort
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t      state, next_state;
  logic [2:0]  f3_q;
  logic        issue;        // first cycle of a WAIT state: fire the unit start

  logic        c_valid;
  logic [31:0] c_a, c_b, c_q, c_r;
  logic        c_signed;

  logic accept, in_dbz, in_ovf, in_hit, in_fast;

  // Fast-path and cache decisions are taken on the incoming operands so a
  // locally answered divide reaches DONE straight from IDLE.
  assign accept  = (state == IDLE) && start && !flush;
  assign in_dbz  = (rs2_data == 32'h0);
  assign in_ovf  = !funct3[0] && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  assign in_hit  = DIV_CACHE_EN && c_valid && (c_a == rs1_data) && (c_b == rs2_data)
                   && (c_signed == !funct3[0]);
  assign in_fast = in_dbz || in_ovf || in_hit;

  assign mul_signed_a = (f3_q[1:0] != 2'b11);
  assign mul_signed_b = !f3_q[1];
  assign div_signed   = !f3_q[0];

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    mul_start  = 1'b0;
    div_start  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall = 1'b1;
          if (!funct3[2])   next_state = MUL_WAIT;
          else if (in_fast) next_state = DONE;
          else              next_state = DIV_WAIT;
        end
      end
      MUL_WAIT: begin
        stall     = 1'b1;
        mul_start = issue && !flush;
        if (flush) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else if (mul_done) begin
          next_state = DONE;
        end
      end
      DIV_WAIT: begin
        stall     = 1'b1;
        div_start = issue && !flush;
        if (flush) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else if (div_done) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = !flush;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Units share nRST, so nothing is signalled to them while it is low.
    if (!nRST) begin
      stall     = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      mul_start = 1'b0;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      f3_q     <= 3'b000;
      op_a     <= 32'h0;
      op_b     <= 32'h0;
      result   <= 32'h0;
      issue    <= 1'b0;
      c_valid  <= 1'b0;
      c_a      <= 32'h0;
      c_b      <= 32'h0;
      c_q      <= 32'h0;
      c_r      <= 32'h0;
      c_signed <= 1'b0;
    end else begin
      issue <= 1'b0;
      if (accept) begin
        f3_q <= funct3;
        op_a <= rs1_data;
        op_b <= rs2_data;
        if (!funct3[2])   issue  <= 1'b1;
        else if (in_dbz)  result <= funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        else if (in_ovf)  result <= funct3[1] ? 32'h0 : 32'h8000_0000;
        else if (in_hit)  result <= funct3[1] ? c_r : c_q;
        else              issue  <= 1'b1;
      end
      if ((state == MUL_WAIT) && mul_done && !flush) begin
        result <= (f3_q == 3'b000) ? mul_product[31:0] : mul_product[63:32];
      end
      if ((state == DIV_WAIT) && div_done && !flush) begin
        result   <= f3_q[1] ? div_remainder : div_quotient;
        c_valid  <= 1'b1;
        c_a      <= op_a;
        c_b      <= op_b;
        c_signed <= !f3_q[0];
        c_q      <= div_quotient;
        c_r      <= div_remainder;
      end
    end
  end

endmodule
